// File: rtl/sad_block_search.sv
// rtl/sad_block_search.sv - block SAD accumulation with minimum-SAD candidate search
//
// Accumulates |A-B| over PIXELS pixel pairs per candidate block and tracks the
// smallest SAD (and its candidate index) over CANDIDATES candidates per run.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse, begins a run when idle (ignored while busy)
//   pix_valid  A_data/B_data carry a pixel pair
//   A_data     current-block pixel, unsigned 8 bit
//   B_data     candidate-block pixel, unsigned 8 bit
//   ready      pair accepted this cycle when pix_valid is also high
//   busy       search run in progress
//   sad        SAD of most recently completed candidate
//   sad_valid  one-cycle pulse, sad just updated
//   best_sad   minimum SAD of the current/last run
//   best_idx   candidate index of best_sad
//   done       one-cycle pulse, run complete and best_* final

module sad_block_search #(
    parameter int PIXELS     = 16,
    parameter int CANDIDATES = 8,
    parameter int SUM_W      = 12,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_valid,
    input  logic [7:0]       A_data,
    input  logic [7:0]       B_data,
    output logic             ready,
    output logic             busy,
    output logic [SUM_W-1:0] sad,
    output logic             sad_valid,
    output logic [SUM_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx,
    output logic             done
);

    localparam int PIX_W = $clog2(PIXELS);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(PIXELS - 1);
    localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(CANDIDATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_UPDATE
    } state_t;

    state_t           state_q, state_d;
    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic             drain_q, drain_d;
    logic [7:0]       diff_q, diff_d;
    logic             diff_v_q, diff_v_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sad_q, sad_d;
    logic             sad_valid_q, sad_valid_d;
    logic [SUM_W-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             done_q, done_d;

    logic             accept;
    logic [8:0]       diff_wide;
    logic [8:0]       diff_neg;
    logic [7:0]       diff_abs;

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        cand_d      = cand_q;
        drain_d     = drain_q;
        diff_d      = diff_q;
        diff_v_d    = 1'b0;
        acc_d       = acc_q;
        sad_d       = sad_q;
        sad_valid_d = 1'b0;
        best_sad_d  = best_sad_q;
        best_idx_d  = best_idx_q;
        done_d      = 1'b0;

        accept = (state_q == S_ACCUM) && pix_valid;

        // 9-bit difference so a negative result is seen as such; the
        // magnitude of -255..255 always fits back into 8 bits.
        diff_wide = {1'b0, A_data} - {1'b0, B_data};
        diff_neg  = ~diff_wide + 9'd1;
        diff_abs  = diff_wide[8] ? diff_neg[7:0] : diff_wide[7:0];

        if (accept) begin
            diff_d   = diff_abs;
            diff_v_d = 1'b1;
        end

        // Stage 2: a registered difference joins the running sum one cycle later.
        if (diff_v_q) begin
            acc_d = acc_q + SUM_W'(diff_q);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ACCUM;
                    pix_cnt_d = '0;
                    cand_d    = '0;
                    acc_d     = '0;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    if (pix_cnt_q == LAST_PIX) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                // Two cycles: the last difference is registered, then summed.
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d     = S_UPDATE;
                    sad_d       = acc_q;
                    sad_valid_d = 1'b1;
                end
            end
            S_UPDATE: begin
                // Strict compare: on a tie the earlier candidate is kept.
                if ((cand_q == '0) || (sad_q < best_sad_q)) begin
                    best_sad_d = sad_q;
                    best_idx_d = cand_q;
                end
                acc_d     = '0;
                pix_cnt_d = '0;
                if (cand_q == LAST_CAND) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cand_d  = cand_q + 1'b1;
                    state_d = S_ACCUM;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pix_cnt_q   <= '0;
            cand_q      <= '0;
            drain_q     <= 1'b0;
            diff_q      <= '0;
            diff_v_q    <= 1'b0;
            acc_q       <= '0;
            sad_q       <= '0;
            sad_valid_q <= 1'b0;
            best_sad_q  <= '0;
            best_idx_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            cand_q      <= cand_d;
            drain_q     <= drain_d;
            diff_q      <= diff_d;
            diff_v_q    <= diff_v_d;
            acc_q       <= acc_d;
            sad_q       <= sad_d;
            sad_valid_q <= sad_valid_d;
            best_sad_q  <= best_sad_d;
            best_idx_q  <= best_idx_d;
            done_q      <= done_d;
        end
    end

    assign ready     = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign sad       = sad_q;
    assign sad_valid = sad_valid_q;
    assign best_sad  = best_sad_q;
    assign best_idx  = best_idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sad_block_search.sv
// tb/tb_sad_block_search.sv - scoreboard bench for sad_block_search

module tb_sad_block_search;

    localparam int PIXELS = 16;
    localparam int CANDS  = 8;
    localparam int SUM_W  = 12;
    localparam int IDX_W  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             pix_valid = 1'b0;
    logic [7:0]       A_data = '0;
    logic [7:0]       B_data = '0;
    logic             ready;
    logic             busy;
    logic [SUM_W-1:0] sad;
    logic             sad_valid;
    logic [SUM_W-1:0] best_sad;
    logic [IDX_W-1:0] best_idx;
    logic             done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int exp_sad_q[$];
    int exp_sad_cyc_q[$];
    int exp_best_q[$];
    int exp_bidx_q[$];
    int exp_done_cyc_q[$];

    int diff_tab[8] = '{9, 7, 3, 5, 3, 8, 1, 1};

    sad_block_search #(
        .PIXELS(PIXELS), .CANDIDATES(CANDS), .SUM_W(SUM_W), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
        .A_data(A_data), .B_data(B_data), .ready(ready), .busy(busy),
        .sad(sad), .sad_valid(sad_valid), .best_sad(best_sad),
        .best_idx(best_idx), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT reports a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (sad_valid) begin
                if (exp_sad_q.size() == 0) begin
                    check("spurious_sad_valid", 1, 0);
                end else begin
                    check("sad", int'(sad), exp_sad_q.pop_front());
                    check("sad_latency", cyc, exp_sad_cyc_q.pop_front());
                end
            end
            if (done) begin
                if (exp_best_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    check("best_sad", int'(best_sad), exp_best_q.pop_front());
                    check("best_idx", int'(best_idx), exp_bidx_q.pop_front());
                    check("done_latency", cyc, exp_done_cyc_q.pop_front());
                    check("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, int'(ready), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_sad"}, int'(sad), 0);
        check({tag, "_sad_valid"}, int'(sad_valid), 0);
        check({tag, "_best_sad"}, int'(best_sad), 0);
        check({tag, "_best_idx"}, int'(best_idx), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // mode 0: random pixels; 1: uniform |A-B| from diff_tab; 2: 200/50 vs 10/250
    task automatic gen_pair(input int mode, input int cand, input int pix,
                            output int a, output int b);
        int base;
        case (mode)
            1: begin
                base = $urandom_range(0, 255 - diff_tab[cand]);
                if (pix % 2 == 0) begin a = base + diff_tab[cand]; b = base; end
                else begin a = base; b = base + diff_tab[cand]; end
            end
            2: begin
                if (cand % 2 == 0) begin a = 200; b = 50; end
                else begin a = 10; b = 250; end
            end
            default: begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
            end
        endcase
    endtask

    // gap_mode 0: none; 1: alternate; 2: random. abort_cand < 0 disables abort.
    task automatic run_search(input int mode, input int gap_mode, input int stray,
                              input int abort_cand, input int abort_pix);
        int cand = 0;
        int pix = 0;
        int sum = 0;
        int best = 0;
        int bidx = 0;
        int guard = 0;
        int wait_cnt = 0;
        int a, b, v;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cand < CANDS && guard < 3000) begin
            guard++;
            if (cand == abort_cand && pix == abort_pix) begin
                pix_valid = 1'b0;
                start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                check_reset_outputs("abort");
                rst = 1'b0;
                return;
            end
            gen_pair(mode, cand, pix, a, b);
            if (!ready) begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
            end
            case (gap_mode)
                1: v = cyc % 2;
                2: v = ($urandom_range(0, 2) != 0) ? 1 : 0;
                default: v = 1;
            endcase
            pix_valid = v[0];
            A_data = 8'(a);
            B_data = 8'(b);
            start = (stray != 0) && ($urandom_range(0, 5) == 0);
            if (ready && v != 0) begin
                sum += (a > b) ? a - b : b - a;
                pix++;
                if (pix == PIXELS) begin
                    exp_sad_q.push_back(sum);
                    exp_sad_cyc_q.push_back(cyc + 3);
                    if (cand == 0 || sum < best) begin
                        best = sum;
                        bidx = cand;
                    end
                    if (cand == CANDS - 1) begin
                        exp_best_q.push_back(best);
                        exp_bidx_q.push_back(bidx);
                        exp_done_cyc_q.push_back(cyc + 4);
                    end
                    cand++;
                    pix = 0;
                    sum = 0;
                end
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        start = 1'b0;
        check("issue_timeout", int'(cand), CANDS);
        while (busy && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("run_end_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("best_sad_hold", int'(best_sad), best);
        check("best_idx_hold", int'(best_idx), bidx);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        run_search(2, 0, 0, -1, 0);
        run_search(1, 0, 0, -1, 0);
        run_search(1, 1, 1, -1, 0);
        run_search(0, 1, 1, -1, 0);
        run_search(0, 2, 1, 2, 7);
        repeat (5) @(negedge clk);
        check("after_abort_idle", int'(busy), 0);
        run_search(0, 2, 0, -1, 0);
        for (int r = 0; r < 3; r++) begin
            run_search(0, 2, 1, -1, 0);
        end
        repeat (5) @(negedge clk);
        check("leftover_sad", exp_sad_q.size(), 0);
        check("leftover_done", exp_best_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
